riscv_core_mul_in: RTL and testbench

RISCV_CORE_MUL_IN -- requirements
Module: riscv_core_mul_in

---
 rtl/riscv_core_mul_in.sv | 190 +++++++++++++++++++
 tb/tb_riscv_core_mul_in.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mul_in.sv
// Sequential shift-add multiplier front end: operand sign handling and unsigned magnitude product.
// Define MUL_IN_RADIX4_EN to retire two multiplier bits per BUSY cycle instead of one.
module riscv_core_mul_in #(
    parameter int unsigned XLEN = 64
) (
    input  logic                i_mul_in_clk,
    input  logic                i_mul_in_rst,
    input  logic                i_mul_in_valid,
    output logic                o_mul_in_ready,
    input  logic [XLEN-1:0]     i_mul_in_srcA,
    input  logic [XLEN-1:0]     i_mul_in_srcB,
    input  logic [1:0]          i_mul_in_control,
    input  logic                i_mul_in_isword,
    input  logic                i_mul_in_flush,
    output logic                o_mul_in_valid,
    input  logic                i_mul_in_ready,
    output logic                o_mul_in_srcA_Dsign,
    output logic                o_mul_in_srcB_Dsign,
    output logic                o_mul_in_srcA_Wsign,
    output logic                o_mul_in_srcB_Wsign,
    output logic [1:0]          o_mul_in_control,
    output logic                o_mul_in_isword,
    output logic [2*XLEN-1:0]   o_mul_in_product
);

    localparam int unsigned HALF = XLEN / 2;
`ifdef MUL_IN_RADIX4_EN
    localparam int unsigned STEP_BITS = 2;
`else
    localparam int unsigned STEP_BITS = 1;
`endif
    localparam int unsigned N_D = XLEN / STEP_BITS;
    localparam int unsigned N_W = HALF / STEP_BITS;
    localparam int unsigned CW  = $clog2(N_D + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [2*XLEN-1:0]  prod_q, prod_d;
    logic               a_dsign_q, a_dsign_d;
    logic               b_dsign_q, b_dsign_d;
    logic               a_wsign_q, a_wsign_d;
    logic               b_wsign_q, b_wsign_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               isword_q, isword_d;

    logic               dsa, dsb, wsa, wsb;
    logic [XLEN-1:0]    op_a, op_b, mag_a, mag_b;
    logic [2*XLEN-1:0]  pp;
    logic [CW-1:0]      last_step;

    // Sign flags and magnitudes of the incoming request operands.
    always_comb begin
        wsa = i_mul_in_isword & i_mul_in_srcA[HALF-1];
        wsb = i_mul_in_isword & i_mul_in_srcB[HALF-1];
        dsa = 1'b0;
        dsb = 1'b0;
        if (!i_mul_in_isword) begin
            case (i_mul_in_control)
                2'b00, 2'b01: begin
                    dsa = i_mul_in_srcA[XLEN-1];
                    dsb = i_mul_in_srcB[XLEN-1];
                end
                2'b10: dsa = i_mul_in_srcA[XLEN-1];
                default: ;
            endcase
        end
        op_a = i_mul_in_isword ? {{HALF{i_mul_in_srcA[HALF-1]}}, i_mul_in_srcA[HALF-1:0]}
                               : i_mul_in_srcA;
        op_b = i_mul_in_isword ? {{HALF{i_mul_in_srcB[HALF-1]}}, i_mul_in_srcB[HALF-1:0]}
                               : i_mul_in_srcB;
        // The most-negative value negates to itself, which reads correctly as 2^(XLEN-1) unsigned.
        mag_a = (dsa | wsa) ? -op_a : op_a;
        mag_b = (dsb | wsb) ? -op_b : op_b;
    end

    always_comb begin
`ifdef MUL_IN_RADIX4_EN
        pp = (mplier_q[0] ? mcand_q : '0)
           + (mplier_q[1] ? {mcand_q[2*XLEN-2:0], 1'b0} : '0);
`else
        pp = mplier_q[0] ? mcand_q : '0;
`endif
        last_step = isword_q ? CW'(N_W - 1) : CW'(N_D - 1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        a_dsign_d = a_dsign_q;
        b_dsign_d = b_dsign_q;
        a_wsign_d = a_wsign_q;
        b_wsign_d = b_wsign_q;
        ctrl_d    = ctrl_q;
        isword_d  = isword_q;

        case (state_q)
            IDLE: begin
                if (i_mul_in_valid) begin
                    state_d   = BUSY;
                    cnt_d     = '0;
                    mcand_d   = {{XLEN{1'b0}}, mag_a};
                    mplier_d  = mag_b;
                    prod_d    = '0;
                    a_dsign_d = dsa;
                    b_dsign_d = dsb;
                    a_wsign_d = wsa;
                    b_wsign_d = wsb;
                    ctrl_d    = i_mul_in_control;
                    isword_d  = i_mul_in_isword;
                end
            end
            BUSY: begin
                if (i_mul_in_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    prod_d  = '0;
                end else begin
                    prod_d   = prod_q + pp;
                    mcand_d  = mcand_q << STEP_BITS;
                    mplier_d = mplier_q >> STEP_BITS;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == last_step) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_mul_in_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    prod_d  = '0;
                end else if (i_mul_in_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_mul_in_clk) begin
        if (i_mul_in_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            a_dsign_q <= 1'b0;
            b_dsign_q <= 1'b0;
            a_wsign_q <= 1'b0;
            b_wsign_q <= 1'b0;
            ctrl_q    <= '0;
            isword_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            a_dsign_q <= a_dsign_d;
            b_dsign_q <= b_dsign_d;
            a_wsign_q <= a_wsign_d;
            b_wsign_q <= b_wsign_d;
            ctrl_q    <= ctrl_d;
            isword_q  <= isword_d;
        end
    end

    assign o_mul_in_ready      = (state_q == IDLE);
    assign o_mul_in_valid      = (state_q == DONE);
    assign o_mul_in_srcA_Dsign = a_dsign_q;
    assign o_mul_in_srcB_Dsign = b_dsign_q;
    assign o_mul_in_srcA_Wsign = a_wsign_q;
    assign o_mul_in_srcB_Wsign = b_wsign_q;
    assign o_mul_in_control    = ctrl_q;
    assign o_mul_in_isword     = isword_q;
    assign o_mul_in_product    = prod_q;

endmodule

// File: tb/tb_riscv_core_mul_in.sv
// Scoreboard bench for riscv_core_mul_in (XLEN=64); honours MUL_IN_RADIX4_EN for BUSY length.
module tb_riscv_core_mul_in;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [63:0]    srcA, srcB;
    logic [1:0]     ctrl;
    logic           isword;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic           dA, dB, wA, wB;
    logic [1:0]     o_ctrl;
    logic           o_isword;
    logic [127:0]   product;

    typedef struct {
        logic [127:0] prod;
        logic [3:0]   flags;   // {dA, dB, wA, wB}
        logic [1:0]   ctrl;
        logic         isword;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    riscv_core_mul_in #(.XLEN(64)) dut (
        .i_mul_in_clk        (clk),
        .i_mul_in_rst        (rst),
        .i_mul_in_valid      (in_valid),
        .o_mul_in_ready      (in_ready),
        .i_mul_in_srcA       (srcA),
        .i_mul_in_srcB       (srcB),
        .i_mul_in_control    (ctrl),
        .i_mul_in_isword     (isword),
        .i_mul_in_flush      (flush),
        .o_mul_in_valid      (out_valid),
        .i_mul_in_ready      (out_ready),
        .o_mul_in_srcA_Dsign (dA),
        .o_mul_in_srcB_Dsign (dB),
        .o_mul_in_srcA_Wsign (wA),
        .o_mul_in_srcB_Wsign (wB),
        .o_mul_in_control    (o_ctrl),
        .o_mul_in_isword     (o_isword),
        .o_mul_in_product    (product)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] c, input logic w);
        exp_t e;
        logic [127:0] ax, bx, p;
        logic sa, sbb;
        if (w) begin
            sa  = a[31];
            sbb = b[31];
            ax  = {{96{a[31]}}, a[31:0]};
            bx  = {{96{b[31]}}, b[31:0]};
            e.flags = {2'b00, sa, sbb};
        end else begin
            sa  = (c != 2'b11) ? a[63] : 1'b0;
            sbb = (c <= 2'b01) ? b[63] : 1'b0;
            ax  = sa  ? {{64{a[63]}}, a} : {64'd0, a};
            bx  = sbb ? {{64{b[63]}}, b} : {64'd0, b};
            e.flags = {sa, sbb, 2'b00};
        end
        p = ax * bx;
        if (sa ^ sbb) p = -p;
        e.prod   = p;
        e.ctrl   = c;
        e.isword = w;
`ifdef MUL_IN_RADIX4_EN
        e.lat = w ? 16 : 32;
`else
        e.lat = w ? 32 : 64;
`endif
        return e;
    endfunction

    // Starts and ends on a falling edge; returns just after the accepting edge.
    task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                             input logic w, input logic fl, input bit push);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready=%b required 1", in_ready);
        end
        srcA = a; srcB = b; ctrl = c; isword = w; flush = fl; in_valid = 1'b1;
        if (push) sb.push_back(model(a, b, c, w));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int m = 0;
        while (!out_valid && m < 200) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s valid_timeout: valid=%b after %0d cycles, required 1", name, out_valid, m);
            if (sb.size() > 0) cur = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_result: product=%h, scoreboard empty", name, product);
            return;
        end
        cur = sb.pop_front();
        if (m !== cur.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, m, cur.lat);
        end
        checks++;
        if (product !== cur.prod) begin
            errors++;
            $display("FAIL %s product: got %h required %h", name, product, cur.prod);
        end
        checks++;
        if ({dA, dB, wA, wB} !== cur.flags) begin
            errors++;
            $display("FAIL %s flags: got %b required %b", name, {dA, dB, wA, wB}, cur.flags);
        end
        checks++;
        if (o_ctrl !== cur.ctrl || o_isword !== cur.isword || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s fields: ctrl=%b isword=%b ready=%b required %b %b 0",
                     name, o_ctrl, o_isword, in_ready, cur.ctrl, cur.isword);
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s consume: valid=%b ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if (product !== 128'd0 || {dA, dB, wA, wB} !== 4'b0 || o_ctrl !== 2'b0 || o_isword !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: product=%h flags=%b ctrl=%b isword=%b required all 0",
                     product, {dA, dB, wA, wB}, o_ctrl, o_isword);
        end
    endtask

    task automatic test_directed;
        drive_req(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 1'b0, 1'b0, 1);
        wait_result("mul_neg3x5");
        consume("mul_neg3x5");
        drive_req(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 1'b0, 1);
        wait_result("mulhu_max");
        consume("mulhu_max");
        drive_req(64'h0000_0000_8000_0000, 64'd2, 2'b00, 1'b1, 1'b0, 1);
        wait_result("mulw_minint");
        checks++;
        if (product[127:64] !== 64'd0) begin
            errors++;
            $display("FAIL mulw_upper: got %h required 0", product[127:64]);
        end
        consume("mulw_minint");
        drive_req(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1'b0, 1);
        wait_result("mulhsu_min");
        consume("mulhsu_min");
        drive_req(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 1'b0, 1);
        wait_result("mulh_minmin");
        consume("mulh_minmin");
    endtask

    task automatic test_hold;
        drive_req(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 2'b01, 1'b0, 1'b0, 1);
        wait_result("hold");
        for (int i = 0; i < 5; i++) begin
            // a new request during DONE must be ignored
            in_valid = 1'b1;
            srcA = 64'd7;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== cur.prod
                || {dA, dB, wA, wB} !== cur.flags || o_ctrl !== cur.ctrl) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b ready=%b product=%h required 1 0 %h",
                         i, out_valid, in_ready, product, cur.prod);
            end
        end
        in_valid = 1'b0;
        consume("hold");
    endtask

    task automatic test_flush;
        int seen;
        drive_req(64'd123456789, 64'd987654321, 2'b00, 1'b0, 1'b0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_valid: valid seen %0d cycles, required 0", seen);
        end
        // flush beats consumer ready in DONE
        drive_req(64'd3, 64'd4, 2'b11, 1'b1, 1'b0, 0);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        // flush alongside a request in IDLE: the request is accepted
        drive_req(64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 2'b00, 1'b0, 1'b1, 1);
        wait_result("flush_idle_accept");
        consume("flush_idle_accept");
    endtask

    task automatic test_reset_busy;
        drive_req(64'hDEAD_BEEF_CAFE_F00D, 64'h8765_4321_0FED_CBA9, 2'b10, 1'b0, 1'b0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 128'd0
            || {dA, dB, wA, wB} !== 4'b0 || o_ctrl !== 2'b0 || o_isword !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: ready=%b valid=%b product=%h flags=%b ctrl=%b isword=%b",
                     in_ready, out_valid, product, {dA, dB, wA, wB}, o_ctrl, o_isword);
        end
        for (int i = 0; i < 80; i++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_valid: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a, b;
        logic [1:0]  c;
        logic        w;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = 2'($urandom_range(0, 3));
            w = (c == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == 0) begin a = 64'hFFFF_FFFF_8000_0000; b = 64'h0000_0000_8000_0000; c = 2'b00; w = 1'b1; end
            if (i == 1) begin a = 64'h8000_0000_0000_0000; b = 64'd0; end
            drive_req(a, b, c, w, 1'b0, 1);
            // junk request while BUSY must not disturb the result
            in_valid = 1'b1;
            srcA = ~a;
            srcB = 64'd1;
            wait_result("b2b");
            in_valid = 1'b0;
            consume("b2b");
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; srcA = '0; srcB = '0; ctrl = '0;
        isword = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_hold;
        test_flush;
        test_reset_busy;
        test_back_to_back;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
